mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/uart_fifo.sv | 52 +++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Address map and transmitter state type shared by the MMIO UART slice.
package mmio_pkg;

    localparam logic [31:0] UART_BASE   = 32'hFFFF_0000;
    localparam logic [3:0]  TXDATA_OFF  = 4'h0;
    localparam logic [3:0]  STATUS_OFF  = 4'h4;
    localparam logic [3:0]  BAUDDIV_OFF = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bundle seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;

    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        dmem_we;

    modport master (
        output we, a, wd,
        input  rd, hit, dmem_we
    );

    modport slave (
        input  we, a, wd,
        output rd, hit, dmem_we
    );

endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the transmitter; a push while full succeeds only
// when a pop happens on the same edge.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers,
// byte FIFO and a registered serial output.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);

    uart_state_t state, state_d;
    logic [7:0]  shift, shift_d;
    logic [15:0] divisor;
    logic [15:0] div_lat, div_lat_d;
    logic [15:0] baud, baud_d;
    logic [2:0]  bitn, bitn_d;
    logic        tx_d;
    logic        overflow;
    logic        pop;
    logic [7:0]  fifo_dout;
    logic        full, empty, busy, bit_end;
    logic        sel_tx, sel_st, sel_bd;
    logic        wr_tx, wr_st, wr_bd;

    assign bus.hit     = (bus.a[31:4] == UART_BASE[31:4]);
    assign bus.dmem_we = bus.we & ~bus.hit;

    assign sel_tx = bus.hit & (bus.a[3:2] == TXDATA_OFF[3:2]);
    assign sel_st = bus.hit & (bus.a[3:2] == STATUS_OFF[3:2]);
    assign sel_bd = bus.hit & (bus.a[3:2] == BAUDDIV_OFF[3:2]);
    assign wr_tx  = bus.we & sel_tx;
    assign wr_st  = bus.we & sel_st;
    assign wr_bd  = bus.we & sel_bd;

    assign busy = (state != IDLE) | ~empty;

    always_comb begin
        bus.rd = '0;
        unique case (1'b1)
            sel_st:  bus.rd = {28'b0, empty, overflow, full, busy};
            sel_bd:  bus.rd = {16'b0, divisor};
            default: bus.rd = '0;
        endcase
    end

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (pop),
        .din   (bus.wd[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // A drop sets overflow even when a STATUS write clears it that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            divisor  <= DEFAULT_DIV;
        end else begin
            if (wr_tx && full && !pop)
                overflow <= 1'b1;
            else if (wr_st)
                overflow <= 1'b0;
            if (wr_bd)
                divisor <= (bus.wd[15:0] == '0) ? 16'd1 : bus.wd[15:0];
        end
    end

    assign bit_end = (baud == div_lat - 16'd1);

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        div_lat_d = div_lat;
        baud_d    = baud;
        bitn_d    = bitn;
        pop       = 1'b0;
        tx_d      = 1'b1;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    div_lat_d = divisor;
                    baud_d    = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bitn_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bitn == 3'd7)
                        state_d = STOP;
                    else
                        bitn_d = bitn + 3'd1;
                end else begin
                    baud_d = baud + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so tx stays registered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            div_lat <= DEFAULT_DIV;
            baud    <= '0;
            bitn    <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            div_lat <= div_lat_d;
            baud    <= baud_d;
            bitn    <= bitn_d;
            tx      <= tx_d;
        end
    end

endmodule
